ex_mem_reg: RTL and testbench
=============================

EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, ALU result and store data width.
REQ-002 SHALL have parameter size, default 5, register-number width, matching the RegDst write-register mux.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hold current contents.
REQ-006 SHALL have port flush  input  1  load a bubble instead of EX contents.
REQ-007 SHALL have port ex_valid  input  1  EX stage holds a real instruction.
REQ-008 SHALL have ports ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  input  1 each  EX control bits.
REQ-009 SHALL have port ex_alu_result  input  DATA_WIDTH  ALU output.
REQ-010 SHALL have port ex_store_data  input  DATA_WIDTH  rt value for stores.
REQ-011 SHALL have port ex_write_reg  input  size  destination register from the RegDst mux.
REQ-012 SHALL have outputs mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg (1 each), mem_alu_result, mem_store_data (DATA_WIDTH), mem_write_reg (size): registered copies for MEM stage.
REQ-013 SHALL have port bubble_count  output  16  count of bubbles inserted by flush.

Function
REQ-014 SHALL apply per-edge priority: reset > flush > stall > load.
REQ-015 Load: on rising edge with no reset/flush/stall, all mem_* outputs SHALL take their ex_* inputs (latency 1 cycle).
REQ-016 Stall: all mem_* outputs and bubble_count SHALL hold unchanged.
REQ-017 Flush: mem_valid and all mem control bits SHALL become 0; mem_alu_result, mem_store_data, mem_write_reg SHALL become 0.
REQ-018 Flush asserted together with stall SHALL produce a bubble (flush wins).
REQ-019 If ex_valid=0 on a load, the four mem control bits SHALL be loaded as 0 regardless of their inputs; data fields load normally.
REQ-020 If ex_write_reg=0 on a load, mem_reg_write SHALL be 0 ($zero never written).
REQ-021 mem_mem_read and mem_mem_write both 1 SHALL never be produced; if both inputs are 1, both outputs SHALL be 0 and mem_valid SHALL be 0.
REQ-022 bubble_count SHALL increment by 1 on every flush edge and saturate at 16'hFFFF (no wrap).
REQ-023 All outputs SHALL be driven directly from flops; no combinational input-to-output path.

Reset
REQ-024 On reset edge all outputs, including bubble_count, SHALL become 0.
REQ-025 Reset asserted mid-stall or mid-flush SHALL override both in the same edge.
REQ-026 First edge after reset deasserts SHALL perform a normal load/flush/stall per REQ-014.

Structure
REQ-027 DATA_WIDTH and register-width constants and the priority encoding SHALL live in the shared pipeline constants package used by all pipeline registers.
REQ-028 One sub-module pipe_reg (parameter width; ports clk, reset, en, clr, d, q) SHALL implement the hold/clear flop bank; ex_mem_reg instantiates it for control and data fields.
REQ-029 The saturating bubble counter SHALL be implemented inside ex_mem_reg, not in pipe_reg.

Verification
REQ-030 Reset: reset=1 one edge with all inputs 1 -> every output 0, bubble_count=0.
REQ-031 Load: ex_valid=1, ex_reg_write=1, ex_alu_result=32'h0000_00AB, ex_write_reg=12 -> next edge mem_reg_write=1, mem_alu_result=0xAB, mem_write_reg=12.
REQ-032 Zero-register: ex_write_reg=0, ex_reg_write=1, ex_valid=1 -> mem_reg_write=0, mem_write_reg=0.
REQ-033 Stall then flush: load write_reg=31, stall 3 edges with changing inputs -> outputs stay write_reg=31; then stall=1 and flush=1 -> mem_valid=0, mem_write_reg=0, bubble_count=1.
REQ-034 Saturation: force 65537 consecutive flush edges -> bubble_count=16'hFFFF, unchanged after further flushes.
REQ-035 Illegal control: ex_mem_read=1, ex_mem_write=1, ex_valid=1 -> mem_mem_read=0, mem_mem_write=0, mem_valid=0.

Source files
------------

// File: rtl/ex_mem_reg_pkg.sv
// Shared pipeline-register constants: default widths, control bundle layout and
// the per-edge priority encoding used by every inter-stage register.
package ex_mem_reg_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_REG_W  = 5;
  localparam int BUBBLE_W    = 16;
  localparam logic [BUBBLE_W-1:0] BUBBLE_MAX = '1;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

  // Encoded so that a larger value always wins over a smaller one.
  typedef enum logic [1:0] {
    PRI_LOAD  = 2'd0,
    PRI_STALL = 2'd1,
    PRI_FLUSH = 2'd2,
    PRI_RESET = 2'd3
  } pri_e;

  function automatic pri_e edge_pri(input logic rst, input logic fl, input logic st);
    if (rst)     return PRI_RESET;
    else if (fl) return PRI_FLUSH;
    else if (st) return PRI_STALL;
    else         return PRI_LOAD;
  endfunction

endpackage

// File: rtl/ex_mem_reg_pipe_reg.sv
// Hold/clear flop bank shared by the pipeline registers: reset and clr zero the
// bank, otherwise en loads d and !en holds.
module pipe_reg #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: sanitises EX control bits, captures ALU/store data,
// supports stall/flush and counts the bubbles inserted by flush.
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int DATA_WIDTH = PIPE_DATA_W,
  parameter int size       = PIPE_REG_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_mem_to_reg,
  input  logic [DATA_WIDTH-1:0] ex_alu_result,
  input  logic [DATA_WIDTH-1:0] ex_store_data,
  input  logic [size-1:0]       ex_write_reg,
  output logic                  mem_valid,
  output logic                  mem_reg_write,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  mem_mem_to_reg,
  output logic [DATA_WIDTH-1:0] mem_alu_result,
  output logic [DATA_WIDTH-1:0] mem_store_data,
  output logic [size-1:0]       mem_write_reg,
  output logic [BUBBLE_W-1:0]   bubble_count
);

  localparam int DBUS_W = 2 * DATA_WIDTH + size;

  pri_e                  pri_p0;
  logic                  ld_en_p0;
  logic                  clr_p0;
  logic                  illegal_p0;
  logic                  live_p0;
  ctrl_t                 ctrl_p0;
  ctrl_t                 ctrl_p1;
  logic [DBUS_W-1:0]     data_p0;
  logic [DBUS_W-1:0]     data_p1;
  logic [BUBBLE_W-1:0]   bubble_p1;

  // ---- p0: edge decision and control sanitising ----
  // A simultaneous read+write request is treated as a non-instruction, and a
  // write to $zero is dropped so MEM/WB never see it.
  always_comb begin
    pri_p0     = edge_pri(reset, flush, stall);
    ld_en_p0   = (pri_p0 == PRI_LOAD);
    clr_p0     = (pri_p0 == PRI_FLUSH);
    illegal_p0 = ex_mem_read & ex_mem_write;
    live_p0    = ex_valid & ~illegal_p0;

    ctrl_p0            = '0;
    ctrl_p0.valid      = live_p0;
    ctrl_p0.reg_write  = live_p0 & ex_reg_write & (ex_write_reg != '0);
    ctrl_p0.mem_read   = live_p0 & ex_mem_read;
    ctrl_p0.mem_write  = live_p0 & ex_mem_write;
    ctrl_p0.mem_to_reg = live_p0 & ex_mem_to_reg;

    data_p0 = {ex_alu_result, ex_store_data, ex_write_reg};
  end

  // ---- p1: registered MEM-stage copies ----
  pipe_reg #(.width($bits(ctrl_t))) u_ctrl_reg (
    .clk   (clk),
    .reset (reset),
    .en    (ld_en_p0),
    .clr   (clr_p0),
    .d     (ctrl_p0),
    .q     (ctrl_p1)
  );

  pipe_reg #(.width(DBUS_W)) u_data_reg (
    .clk   (clk),
    .reset (reset),
    .en    (ld_en_p0),
    .clr   (clr_p0),
    .d     (data_p0),
    .q     (data_p1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_p1 <= '0;
    end else if (pri_p0 == PRI_FLUSH && bubble_p1 != BUBBLE_MAX) begin
      bubble_p1 <= bubble_p1 + 1'b1;
    end
  end

  assign mem_valid      = ctrl_p1.valid;
  assign mem_reg_write  = ctrl_p1.reg_write;
  assign mem_mem_read   = ctrl_p1.mem_read;
  assign mem_mem_write  = ctrl_p1.mem_write;
  assign mem_mem_to_reg = ctrl_p1.mem_to_reg;
  assign {mem_alu_result, mem_store_data, mem_write_reg} = data_p1;
  assign bubble_count   = bubble_p1;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed-vector bench for ex_mem_reg with hand-computed expectations.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_write_reg;
  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  logic [31:0] mem_alu_result, mem_store_data;
  logic [4:0]  mem_write_reg;
  logic [15:0] bubble_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_mem_to_reg  (ex_mem_to_reg),
    .ex_alu_result  (ex_alu_result),
    .ex_store_data  (ex_store_data),
    .ex_write_reg   (ex_write_reg),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_read   (mem_mem_read),
    .mem_mem_write  (mem_mem_write),
    .mem_mem_to_reg (mem_mem_to_reg),
    .mem_alu_result (mem_alu_result),
    .mem_store_data (mem_store_data),
    .mem_write_reg  (mem_write_reg),
    .bubble_count   (bubble_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic mr, input logic mw,
                       input logic m2r, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] wr);
    ex_valid = v; ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw;
    ex_mem_to_reg = m2r; ex_alu_result = alu; ex_store_data = sd; ex_write_reg = wr;
  endtask

  task automatic chk_ctrl(input string tag, input logic [4:0] exp);
    chk(tag, {mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg}, exp);
  endtask

  initial begin
    // Reset with every input high
    reset = 1; stall = 1; flush = 1;
    drive(1, 1, 1, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1F);
    step();
    chk_ctrl("rst_ctrl", 5'b00000);
    chk("rst_alu", mem_alu_result, 0);
    chk("rst_sd", mem_store_data, 0);
    chk("rst_wr", mem_write_reg, 0);
    chk("rst_bub", bubble_count, 0);

    // Normal load
    reset = 0; stall = 0; flush = 0;
    drive(1, 1, 0, 0, 0, 32'h0000_00AB, 32'h0000_1234, 5'd12);
    step();
    chk_ctrl("ld_ctrl", 5'b11000);
    chk("ld_alu", mem_alu_result, 32'hAB);
    chk("ld_sd", mem_store_data, 32'h1234);
    chk("ld_wr", mem_write_reg, 12);

    // Write to $zero suppressed
    drive(1, 1, 0, 0, 0, 32'h0000_0010, 32'h0, 5'd0);
    step();
    chk_ctrl("zr_ctrl", 5'b10000);
    chk("zr_wr", mem_write_reg, 0);
    chk("zr_alu", mem_alu_result, 32'h10);

    // Not-valid: controls forced low, data still loads
    drive(0, 1, 1, 0, 1, 32'h0000_0055, 32'h0000_0066, 5'd5);
    step();
    chk_ctrl("nv_ctrl", 5'b00000);
    chk("nv_alu", mem_alu_result, 32'h55);
    chk("nv_wr", mem_write_reg, 5);

    // Illegal read+write
    drive(1, 0, 1, 1, 0, 32'h0000_0100, 32'h0000_0200, 5'd3);
    step();
    chk("ill_rd", mem_mem_read, 0);
    chk("ill_wr", mem_mem_write, 0);
    chk("ill_vld", mem_valid, 0);

    // Legal load instruction
    drive(1, 1, 1, 0, 1, 32'h0000_0400, 32'h0, 5'd7);
    step();
    chk_ctrl("lw_ctrl", 5'b11101);
    chk("lw_wr", mem_write_reg, 7);

    // Store: mem_write only
    drive(1, 0, 0, 1, 0, 32'h0000_0800, 32'hCAFE_F00D, 5'd9);
    step();
    chk_ctrl("sw_ctrl", 5'b10010);
    chk("sw_sd", mem_store_data, 32'hCAFE_F00D);

    // Load write_reg=31, then stall three edges with changing inputs
    drive(1, 1, 0, 0, 0, 32'h0000_DEAD, 32'h0000_BEEF, 5'd31);
    step();
    chk("st0_wr", mem_write_reg, 31);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(i[0], 0, 1, 0, 1, 32'(i + 1), 32'(i + 7), 5'(i + 1));
      step();
      chk("st_wr", mem_write_reg, 31);
      chk("st_alu", mem_alu_result, 32'hDEAD);
      chk_ctrl("st_ctrl", 5'b11000);
      chk("st_bub", bubble_count, 0);
    end

    // Flush while stalled: bubble wins
    flush = 1;
    step();
    chk_ctrl("fs_ctrl", 5'b00000);
    chk("fs_wr", mem_write_reg, 0);
    chk("fs_alu", mem_alu_result, 0);
    chk("fs_bub", bubble_count, 1);

    // Flush alone, then stall alone holds the count
    stall = 0;
    step();
    chk("f2_bub", bubble_count, 2);
    flush = 0; stall = 1;
    drive(1, 1, 0, 0, 0, 32'h1, 32'h2, 5'd4);
    step();
    chk("sh_bub", bubble_count, 2);
    chk("sh_wr", mem_write_reg, 0);

    // Reset overrides simultaneous stall and flush
    reset = 1; flush = 1; stall = 1;
    step();
    chk("rsf_bub", bubble_count, 0);
    chk_ctrl("rsf_ctrl", 5'b00000);

    // First edge after reset is a normal load
    reset = 0; flush = 0; stall = 0;
    drive(1, 1, 0, 0, 0, 32'h0000_0042, 32'h0, 5'd20);
    step();
    chk_ctrl("pr_ctrl", 5'b11000);
    chk("pr_alu", mem_alu_result, 32'h42);
    chk("pr_bub", bubble_count, 0);

    // Saturation: 65537 consecutive flushes, then more
    flush = 1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", bubble_count, 16'hFFFE);
    step();
    chk("sat_ffff", bubble_count, 16'hFFFF);
    step();
    step();
    chk("sat_65537", bubble_count, 16'hFFFF);
    step();
    step();
    chk("sat_hold", bubble_count, 16'hFFFF);
    chk_ctrl("sat_ctrl", 5'b00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
